// File: rtl/mtc_ppa_pkg.sv
// Shared helpers for the mtc_ppa round-robin arbiter slice.
// Helpers operate on a MAX_BITS-wide carrier vector with an explicit
// active width so a single package serves every parametrisation.
package mtc_ppa_pkg;

  localparam int unsigned MAX_BITS = 256;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_e;

  // min(a + b, max_v)
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_v);
    int unsigned s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

  // Bits [k-1:0] set, all others clear
  function automatic logic [MAX_BITS-1:0] bin2therm(input int unsigned k);
    logic [MAX_BITS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      t[i] = (i < k);
    end
    return t;
  endfunction

  // (v + 1) mod n without relying on power-of-two truncation
  function automatic int unsigned mod_inc(input int unsigned v,
                                          input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  // out[(i + a) mod n] = v[i] over the low n bits
  function automatic logic [MAX_BITS-1:0] rot_left(input logic [MAX_BITS-1:0] v,
                                                   input int unsigned n,
                                                   input int unsigned a);
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if (i < n) r[(i + a) % n] = v[i];
    end
    return r;
  endfunction

  // out[i] = v[(i + a) mod n] over the low n bits
  function automatic logic [MAX_BITS-1:0] rot_right(input logic [MAX_BITS-1:0] v,
                                                    input int unsigned n,
                                                    input int unsigned a);
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if (i < n) r[i] = v[(i + a) % n];
    end
    return r;
  endfunction

endpackage

// File: rtl/mtc_ppa_rotator.sv
// Log-depth barrel rotator over WIDTH_N lanes of LANE_W bits each.
// Stage k rotates by (2^k mod WIDTH_N) lanes, so any amount < WIDTH_N is
// correct for non-power-of-two WIDTH_N as well.
module mtc_ppa_rotator
  import mtc_ppa_pkg::*;
#(
  parameter int unsigned WIDTH_N = 8,
  parameter int unsigned LANE_W  = 1,
  parameter rot_dir_e    DIR     = ROT_LEFT,
  localparam int unsigned PTR_W  = $clog2(WIDTH_N),
  localparam int unsigned TOT_W  = WIDTH_N * LANE_W
) (
  input  logic [TOT_W-1:0] data_i,
  input  logic [PTR_W-1:0] amt_i,
  output logic [TOT_W-1:0] data_o
);

  logic [TOT_W-1:0] stage_v;

  // Conditional constant-distance rotate per amount bit
  always_comb begin
    stage_v = data_i;
    for (int unsigned k = 0; k < PTR_W; k++) begin
      if (amt_i[k]) begin
        if (DIR == ROT_LEFT) begin
          stage_v = TOT_W'(rot_left(MAX_BITS'(stage_v), TOT_W,
                                    ((32'd1 << k) % WIDTH_N) * LANE_W));
        end else begin
          stage_v = TOT_W'(rot_right(MAX_BITS'(stage_v), TOT_W,
                                     ((32'd1 << k) % WIDTH_N) * LANE_W));
        end
      end
    end
    data_o = stage_v;
  end

endmodule

// File: rtl/mtc_ppa_rr_arbiter.sv
// Registered round-robin multi-grant arbiter: up to AMOUNT_M one-hot grants
// per transaction, searching from a programmable pointer modulo WIDTH_N.
// Optional build macro MTC_PPA_RR_MASK_EN adds req_mask_i (masked requesters
// are removed from the search before rotation).
module mtc_ppa_rr_arbiter
  import mtc_ppa_pkg::*;
#(
  parameter int unsigned  WIDTH_N  = 10,
  parameter int unsigned  AMOUNT_M = 2,
  localparam int unsigned PTR_W    = $clog2(WIDTH_N),
  localparam int unsigned CNT_W    = $clog2(AMOUNT_M + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH_N-1:0]                req_i,
`ifdef MTC_PPA_RR_MASK_EN
  input  logic [WIDTH_N-1:0]                req_mask_i,
`endif
  input  logic                              req_vld_i,
  output logic                              req_rdy_o,
  input  logic                              mode_rr_i,
  input  logic                              ptr_ld_vld_i,
  input  logic [PTR_W-1:0]                  ptr_ld_i,
  output logic [AMOUNT_M-1:0][WIDTH_N-1:0]  gnt_o,
  output logic [CNT_W-1:0]                  gnt_cnt_o,
  output logic                              gnt_vld_o,
  input  logic                              gnt_rdy_i,
  output logic [PTR_W-1:0]                  ptr_o
);

  logic [AMOUNT_M-1:0][WIDTH_N-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             vld_q;
  logic [PTR_W-1:0]                 ptr_q, rr_ptr_d;

  logic [PTR_W-1:0]                 start_ptr;
  logic [WIDTH_N-1:0]               req_eff, req_rot;
  logic [WIDTH_N*AMOUNT_M-1:0]      col_rot, col;
  int unsigned                      seen;
  logic                             capture;

  assign req_rdy_o = ~vld_q | gnt_rdy_i;
  assign capture   = req_vld_i & req_rdy_o;
  assign start_ptr = mode_rr_i ? ptr_q : '0;

`ifdef MTC_PPA_RR_MASK_EN
  assign req_eff = req_i & ~req_mask_i;
`else
  assign req_eff = req_i;
`endif

  // Bring the search start to bit 0
  mtc_ppa_rotator #(
    .WIDTH_N (WIDTH_N),
    .LANE_W  (1),
    .DIR     (ROT_RIGHT)
  ) u_pre_rot (
    .data_i  (req_eff),
    .amt_i   (start_ptr),
    .data_o  (req_rot)
  );

  // Prefix-count set requests; requester i gets slot = number seen before it
  always_comb begin
    seen    = 0;
    col_rot = '0;
    for (int unsigned i = 0; i < WIDTH_N; i++) begin
      if (req_rot[i]) begin
        col_rot[i*AMOUNT_M +: AMOUNT_M] =
          AMOUNT_M'(bin2therm(seen + 1) & ~bin2therm(seen));
        seen = sat_add(seen, 1, AMOUNT_M);
      end
    end
    cnt_d = CNT_W'(seen);
  end

  // Per-requester slot columns are rotated as AMOUNT_M-bit lanes so one
  // rotator restores original indices for every slot at once.
  mtc_ppa_rotator #(
    .WIDTH_N (WIDTH_N),
    .LANE_W  (AMOUNT_M),
    .DIR     (ROT_LEFT)
  ) u_post_rot (
    .data_i  (col_rot),
    .amt_i   (start_ptr),
    .data_o  (col)
  );

  // Transpose columns into per-slot grants; locate the last granted index
  always_comb begin
    gnt_d    = '0;
    rr_ptr_d = ptr_q;
    for (int unsigned i = 0; i < WIDTH_N; i++) begin
      for (int unsigned k = 0; k < AMOUNT_M; k++) begin
        gnt_d[k][i] = col[i*AMOUNT_M + k];
        if (col[i*AMOUNT_M + k] && (k + 1 == seen)) begin
          rr_ptr_d = PTR_W'(mod_inc(i, WIDTH_N));
        end
      end
    end
  end

  // Output register stage with valid/ready hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (capture) begin
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      vld_q <= 1'b1;
    end else if (gnt_rdy_i) begin
      vld_q <= 1'b0;
    end
  end

  // Priority pointer: valid software load wins over round-robin advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (ptr_ld_vld_i && (32'(ptr_ld_i) < WIDTH_N)) begin
      ptr_q <= ptr_ld_i;
    end else if (capture && mode_rr_i && (cnt_d != '0)) begin
      ptr_q <= rr_ptr_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_cnt_o = cnt_q;
  assign gnt_vld_o = vld_q;
  assign ptr_o     = ptr_q;

  // Upstream must hold a stalled request
  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    (req_vld_i && !req_rdy_o) |=> (req_vld_i && $stable(req_i)));

  // Stalled output beat must not change
  a_gnt_hold: assert property (@(posedge clk) disable iff (reset)
    (gnt_vld_o && !gnt_rdy_i) |=>
      (gnt_vld_o && $stable(gnt_o) && $stable(gnt_cnt_o)));

endmodule

// File: tb/tb_mtc_ppa_rr_arbiter.sv
module tb_mtc_ppa_rr_arbiter;

  localparam int unsigned N = 8;
  localparam int unsigned M = 2;
  localparam int unsigned PW = $clog2(N);
  localparam int unsigned CW = $clog2(M + 1);

  logic                  clk;
  logic                  reset;
  logic [N-1:0]          req_i;
  logic                  req_vld_i;
  logic                  req_rdy_o;
  logic                  mode_rr_i;
  logic                  ptr_ld_vld_i;
  logic [PW-1:0]         ptr_ld_i;
  logic [M-1:0][N-1:0]   gnt_o;
  logic [CW-1:0]         gnt_cnt_o;
  logic                  gnt_vld_o;
  logic                  gnt_rdy_i;
  logic [PW-1:0]         ptr_o;
`ifdef MTC_PPA_RR_MASK_EN
  logic [N-1:0]          req_mask_i;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  mtc_ppa_rr_arbiter #(
    .WIDTH_N  (N),
    .AMOUNT_M (M)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
`ifdef MTC_PPA_RR_MASK_EN
    .req_mask_i   (req_mask_i),
`endif
    .req_vld_i    (req_vld_i),
    .req_rdy_o    (req_rdy_o),
    .mode_rr_i    (mode_rr_i),
    .ptr_ld_vld_i (ptr_ld_vld_i),
    .ptr_ld_i     (ptr_ld_i),
    .gnt_o        (gnt_o),
    .gnt_cnt_o    (gnt_cnt_o),
    .gnt_vld_o    (gnt_vld_o),
    .gnt_rdy_i    (gnt_rdy_i),
    .ptr_o        (ptr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [N-1:0] g0, input logic [N-1:0] g1,
                          input int unsigned cnt, input logic vld, input int unsigned ptr);
    chk({tag, ".g0"},  32'(gnt_o[0]),  32'(g0));
    chk({tag, ".g1"},  32'(gnt_o[1]),  32'(g1));
    chk({tag, ".cnt"}, 32'(gnt_cnt_o), cnt);
    chk({tag, ".vld"}, 32'(gnt_vld_o), 32'(vld));
    chk({tag, ".ptr"}, 32'(ptr_o),     ptr);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    req_i        = '0;
    req_vld_i    = 1'b0;
    mode_rr_i    = 1'b1;
    ptr_ld_vld_i = 1'b0;
    ptr_ld_i     = '0;
    gnt_rdy_i    = 1'b1;
`ifdef MTC_PPA_RR_MASK_EN
    req_mask_i   = '0;
`endif

    #3;
    chk_beat("reset", 8'h00, 8'h00, 0, 1'b0, 0);
    chk("reset.rdy", 32'(req_rdy_o), 1);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin from 0: bits 2,4 granted, pointer past 4
    req_i = 8'b1011_0100; req_vld_i = 1'b1;
    step();
    chk_beat("rr0", 8'b0000_0100, 8'b0001_0000, 2, 1'b1, 5);

    // Same request from 5: bits 5,7 granted, pointer wraps
    step();
    chk_beat("rr5", 8'b0010_0000, 8'b1000_0000, 2, 1'b1, 0);

    // Idle cycle with pointer load; output clears, grants hold
    req_vld_i = 1'b0; ptr_ld_vld_i = 1'b1; ptr_ld_i = 3'd6;
    step();
    chk_beat("ld6", 8'b0010_0000, 8'b1000_0000, 2, 1'b0, 6);

    // From 6: order 6,7,0,1 -> bits 0,1
    ptr_ld_vld_i = 1'b0; req_i = 8'b0000_0011; req_vld_i = 1'b1;
    step();
    chk_beat("rr6", 8'b0000_0001, 8'b0000_0010, 2, 1'b1, 2);

    // Capture uses old ptr 2 (order 2..7,0,1 -> bits 7,0); same-cycle load of 4 wins
    req_i = 8'b1000_0001; ptr_ld_vld_i = 1'b1; ptr_ld_i = 3'd4;
    step();
    chk_beat("ldcap", 8'b1000_0000, 8'b0000_0001, 2, 1'b1, 4);

    // Backpressure for 3 clocks with a second request pending
    ptr_ld_vld_i = 1'b0; req_i = 8'b0000_0110; gnt_rdy_i = 1'b0;
    #1;
    chk("bp.rdy", 32'(req_rdy_o), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat("bp", 8'b1000_0000, 8'b0000_0001, 2, 1'b1, 4);
      chk("bp.rdy_hold", 32'(req_rdy_o), 0);
    end
    gnt_rdy_i = 1'b1;
    #1;
    chk("bp.rdy_rel", 32'(req_rdy_o), 1);
    // From 4: order 4..7,0..3 -> bits 1,2; pointer 3
    step();
    chk_beat("bp.beat2", 8'b0000_0010, 8'b0000_0100, 2, 1'b1, 3);

    // Drain: valid drops, data holds
    req_vld_i = 1'b0;
    step();
    chk_beat("drain", 8'b0000_0010, 8'b0000_0100, 2, 1'b0, 3);

    // Fixed priority with ptr=5: search from 0 -> bits 0,5; ptr unchanged
    ptr_ld_vld_i = 1'b1; ptr_ld_i = 3'd5;
    step();
    chk("fp.ptr_ld", 32'(ptr_o), 5);
    ptr_ld_vld_i = 1'b0; mode_rr_i = 1'b0; req_i = 8'b1110_0001; req_vld_i = 1'b1;
    step();
    chk_beat("fp", 8'b0000_0001, 8'b0010_0000, 2, 1'b1, 5);

    // Empty request is still a beat, with zero count
    req_i = 8'b0000_0000;
    step();
    chk_beat("empty", 8'h00, 8'h00, 0, 1'b1, 5);

    // Single request: only slot 0 used, count 1, rr pointer past it
    mode_rr_i = 1'b1; req_i = 8'b0100_0000;
    step();
    chk_beat("single", 8'b0100_0000, 8'h00, 1, 1'b1, 7);

    // Empty capture in rr mode with same-cycle load of 3
    req_i = 8'b0000_0000; ptr_ld_vld_i = 1'b1; ptr_ld_i = 3'd3;
    step();
    chk_beat("pre_rst", 8'h00, 8'h00, 0, 1'b1, 3);
    ptr_ld_vld_i = 1'b0; req_vld_i = 1'b0;

    // Asynchronous reset away from the clock edge
    #2;
    reset = 1'b1;
    #1;
    chk_beat("arst", 8'h00, 8'h00, 0, 1'b0, 0);
    #1;
    reset = 1'b0;

    // First post-reset beat searches from 0
    req_i = 8'b1011_0100; req_vld_i = 1'b1;
    step();
    chk_beat("post_rst", 8'b0000_0100, 8'b0001_0000, 2, 1'b1, 5);
    req_vld_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mtc_ppa_rr_arbiter.md
Name: mtc_ppa_rr_arbiter

Overview:
- Registered, round-robin multi-grant arbiter: up to M grants per transaction from an N-bit request vector.
- Search starts at a programmable priority pointer and wraps modulo N.
- Pointer advances past the last granted requester; software may reload it or force fixed-priority mode.
- Sits between request collectors and M parallel service slots; valid/ready on both sides, one output register stage.

Parameters:
WIDTH_N, 10, number of requesters (>=2)
AMOUNT_M, 2, max grants per transaction (1..WIDTH_N)
PTR_W, $clog2(WIDTH_N), pointer width (derived localparam, not overridable)
CNT_W, $clog2(AMOUNT_M+1), grant-count width (derived localparam)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_i  in  WIDTH_N  request vector
req_vld_i  in  1  request valid
req_rdy_o  out  1  request ready
mode_rr_i  in  1  1=round-robin, 0=fixed priority (search from index 0)
ptr_ld_vld_i  in  1  load priority pointer
ptr_ld_i  in  PTR_W  pointer load value
gnt_o  out  AMOUNT_M x WIDTH_N  per-slot one-hot grant (slot 0 = highest priority)
gnt_cnt_o  out  CNT_W  number of valid slots (0..AMOUNT_M)
gnt_vld_o  out  1  grant valid
gnt_rdy_i  in  1  grant ready
ptr_o  out  PTR_W  current pointer (debug)

Behaviour:
- Reset values: gnt_o=0, gnt_cnt_o=0, gnt_vld_o=0, ptr=0, ptr_o=0. req_rdy_o follows its equation (1 while gnt_vld_o=0).
- req_rdy_o = ~gnt_vld_o | gnt_rdy_i. Full throughput; no combinational path from req_vld_i to req_rdy_o.
- Capture: on req_vld_i & req_rdy_o, the output register loads next cycle. Latency 1 clk.
- Output clear: if gnt_rdy_i and no capture, gnt_vld_o -> 0 and gnt_o/gnt_cnt_o hold their values.
- Output stability: while gnt_vld_o & ~gnt_rdy_i, gnt_o, gnt_cnt_o and gnt_vld_o are stable.
- Search start: s = ptr if mode_rr_i, else 0.
- Search order: s, s+1, …, WIDTH_N-1, 0, …, s-1. Slot k grants the (k+1)-th set request in that order.
- Unused slots are all-zero; gnt_cnt_o = min(popcount(req_i), AMOUNT_M).
- Pointer update on capture, mode_rr_i=1, gnt_cnt>0: ptr <= (index of last granted slot + 1) mod WIDTH_N.
- No update when gnt_cnt=0 or mode_rr_i=0.
- A zero req_i with req_vld_i is still a transaction: output beat with gnt_cnt_o=0.
- Pointer load: ptr_ld_vld_i=1 sets ptr <= ptr_ld_i next cycle, overriding a same-cycle round-robin update.
  - A same-cycle capture uses the old ptr.
  - ptr_ld_i >= WIDTH_N is ignored; ptr unchanged.
- Wrap: index WIDTH_N-1 +1 wraps to 0. Non-power-of-2 WIDTH_N is handled by mod-N increment, not bit truncation.
- Reset mid-transaction drops the pending output beat; the pointer returns to 0.
- Upstream protocol: req_vld_i/req_i held stable while req_vld_i & ~req_rdy_o. Checked by assertions (disable iff reset).
- Timing: the critical path (rotate -> thermometer prefix count -> un-rotate) is fully combinational before the output register.

Optional Feature:
- MTC_PPA_RR_MASK_EN defined:
  - Adds input req_mask_i [WIDTH_N]. Effective request = req_i & ~req_mask_i, sampled at capture.
  - Masked requesters never receive a grant and are skipped for pointer purposes.
- Undefined: port absent; effective request = req_i.

Decomposition:
- Package mtc_ppa_pkg holds:
  - saturating-add function
  - bin-to-thermometer function
  - mod-N increment function
  - rotate-left/rotate-right functions on a WIDTH_N vector
- Sub-module mtc_ppa_rotator (parametrised WIDTH_N, direction parameter): barrel rotate by PTR_W amount. Instantiated twice (pre-rotate requests, un-rotate grants).

Test Plan (WIDTH_N=8, AMOUNT_M=2, mode_rr_i=1, gnt_rdy_i=1 unless stated):
- ptr=0, req_i=8'b1011_0100 -> next clk gnt_o[0]=8'b0000_0100, gnt_o[1]=8'b0001_0000, gnt_cnt_o=2, ptr_o=5.
- Same req again with ptr=5 -> gnt_o[0]=8'b0010_0000, gnt_o[1]=8'b1000_0000, ptr_o=0 (wrap).
- ptr_ld_i=6 loaded, then req_i=8'b0000_0011 -> gnt_o[0]=8'b0000_0001, gnt_o[1]=8'b0000_0010, ptr_o=2.
- gnt_rdy_i=0 for 3 clk with a second request pending -> req_rdy_o=0; gnt_o/gnt_cnt_o/ptr_o unchanged; second beat appears 1 clk after gnt_rdy_i=1.
- mode_rr_i=0, ptr=5, req_i=8'b1110_0001 -> slots 0 and 5 granted, gnt_cnt_o=2, ptr_o stays 5. Then req_i=0 -> gnt_cnt_o=0, gnt_o all zero.
- reset asserted while gnt_vld_o=1, ptr=3 -> gnt_vld_o=0, gnt_o=0, ptr_o=0 immediately (asynchronous); first post-reset beat searches from 0.
